wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile_if.sv | 29 ++
 rtl/wb_regfile.sv | 98 +++++++++
 tb/tb_wb_regfile.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// Writeback-stage bus between the MEM/WB pipeline register, the decode
// stage and the register file. The master side drives writeback fields and
// read indices; the slave side (the register file) returns the operands, the
// selected writeback value and the retire count.
interface wb_regfile_if #(
  parameter int COUNT_W = 32
);
  logic [31:0]        alu_res;
  logic [31:0]        mem_read;
  logic [4:0]         write_reg;
  logic               MemToReg;
  logic               RegWrite;
  logic [4:0]         read_reg1;
  logic [4:0]         read_reg2;
  logic [31:0]        read_data1;
  logic [31:0]        read_data2;
  logic [31:0]        wb_data;
  logic [COUNT_W-1:0] wb_count;

  modport master (
    output alu_res, mem_read, write_reg, MemToReg, RegWrite, read_reg1, read_reg2,
    input  read_data1, read_data2, wb_data, wb_count
  );

  modport slave (
    input  alu_res, mem_read, write_reg, MemToReg, RegWrite, read_reg1, read_reg2,
    output read_data1, read_data2, wb_data, wb_count
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback-stage register file: 32 x 32-bit registers with r0 hardwired to
// zero, writeback data mux, two combinational read ports and a retire counter.
// Optional feature macro: WB_REGFILE_BYPASS_EN -- when defined, a read of the
// register being committed this cycle returns the writeback value
// (write-before-read); when undefined, reads see the stored pre-edge value.
module wb_regfile #(
  parameter int COUNT_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  wb_regfile_if.slave   bus
);

  logic [31:0]        regs_r [32];
  logic [COUNT_W-1:0] count_r;
  logic [31:0]        wb_data_s;
  logic               commit_s;
  logic [31:0]        rd1_s;
  logic [31:0]        rd2_s;

  // Writeback value select: load data or ALU result.
  always_comb begin
    wb_data_s = 32'd0;
    if (bus.MemToReg) begin
      wb_data_s = bus.mem_read;
    end else begin
      wb_data_s = bus.alu_res;
    end
  end

  // A write retires only when enabled and not aimed at the hardwired r0.
  always_comb begin
    commit_s = 1'b0;
    if (bus.RegWrite && (bus.write_reg != 5'd0)) begin
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end
  end

  // Register array: cleared asynchronously, written on qualified commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (commit_s) begin
      regs_r[bus.write_reg] <= wb_data_s;
    end
  end

  // Retire counter: one step per committed write, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (commit_s) begin
      count_r <= count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Read port 1: zero in reset and for r0, optional same-cycle bypass.
  always_comb begin
    rd1_s = 32'd0;
    if (rst) begin
      rd1_s = 32'd0;
    end else if (bus.read_reg1 == 5'd0) begin
      rd1_s = 32'd0;
`ifdef WB_REGFILE_BYPASS_EN
    end else if (commit_s && (bus.read_reg1 == bus.write_reg)) begin
      rd1_s = wb_data_s;
`endif
    end else begin
      rd1_s = regs_r[bus.read_reg1];
    end
  end

  // Read port 2: same policy as port 1, so equal indices give equal data.
  always_comb begin
    rd2_s = 32'd0;
    if (rst) begin
      rd2_s = 32'd0;
    end else if (bus.read_reg2 == 5'd0) begin
      rd2_s = 32'd0;
`ifdef WB_REGFILE_BYPASS_EN
    end else if (commit_s && (bus.read_reg2 == bus.write_reg)) begin
      rd2_s = wb_data_s;
`endif
    end else begin
      rd2_s = regs_r[bus.read_reg2];
    end
  end

  assign bus.wb_data    = wb_data_s;
  assign bus.read_data1 = rd1_s;
  assign bus.read_data2 = rd2_s;
  assign bus.wb_count   = count_r;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized
// writeback traffic compared against an array-based reference model.
module tb_wb_regfile;

  logic clk;
  logic rst;
  int   passed;
  int   total;
  int   model_regs [32];
  int   model_count;

  wb_regfile_if #(.COUNT_W(4)) bus ();

  wb_regfile #(.COUNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_wb();
    return bus.MemToReg ? bus.mem_read : bus.alu_res;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] idx);
    if (rst || idx == 5'd0) return 32'd0;
`ifdef WB_REGFILE_BYPASS_EN
    if (bus.RegWrite && bus.write_reg != 5'd0 && bus.write_reg == idx) return exp_wb();
`endif
    return model_regs[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_regs[i] = 0;
    model_count = 0;
  endtask

  // Apply the edge to the model using pre-edge inputs, then let the DUT clock.
  task automatic tick();
    logic [31:0] v;
    v = exp_wb();
    if (!rst && bus.RegWrite && bus.write_reg != 5'd0) begin
      model_regs[bus.write_reg] = v;
      model_count = (model_count + 1) % 16;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic [4:0] wr, input logic m2r,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [4:0] r1, input logic [4:0] r2);
    bus.RegWrite  = rw;
    bus.write_reg = wr;
    bus.MemToReg  = m2r;
    bus.alu_res   = alu;
    bus.mem_read  = mem;
    bus.read_reg1 = r1;
    bus.read_reg2 = r2;
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_wb_data"}, bus.wb_data, exp_wb());
    check({tag, "_rd1"}, bus.read_data1, exp_read(bus.read_reg1));
    check({tag, "_rd2"}, bus.read_data2, exp_read(bus.read_reg2));
    check({tag, "_count"}, {28'd0, bus.wb_count}, 32'(model_count));
  endtask

  initial begin
    logic [31:0] cnt_hold;
    passed = 0;
    total  = 0;
    model_reset();
    rst = 1'b1;
    drive(1'b1, 5'd9, 1'b0, 32'h1111_2222, 32'h3333_4444, 5'd9, 5'd9);

    // Reset: reads zero, wb_data still muxes, writes suppressed across edges.
    check("rst_rd1", bus.read_data1, 32'd0);
    check("rst_count", {28'd0, bus.wb_count}, 32'd0);
    check("rst_wb_alu", bus.wb_data, 32'h1111_2222);
    bus.MemToReg = 1'b1;
    #1;
    check("rst_wb_mem", bus.wb_data, 32'h3333_4444);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd9, 5'd9);
    check("post_rst_r9", bus.read_data1, 32'd0);
    check("post_rst_count", {28'd0, bus.wb_count}, 32'd0);

    // Mux/commit: load data selected and committed to r7.
    drive(1'b1, 5'd7, 1'b1, 32'h0000_0001, 32'hDEAD_BEEF, 5'd0, 5'd0);
    check("mux_wb", bus.wb_data, 32'hDEAD_BEEF);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd7, 5'd0);
    check("commit_r7", bus.read_data1, 32'hDEAD_BEEF);
    check("commit_count", {28'd0, bus.wb_count}, 32'd1);

    // r0 guard: write to r0 ignored, count unchanged.
    drive(1'b1, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'd0, 5'd7, 5'd0);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd7, 5'd0);
    check("r0_read", bus.read_data2, 32'd0);
    check("r0_count", {28'd0, bus.wb_count}, 32'd1);

    // Same-cycle read of the register being written.
    drive(1'b1, 5'd3, 1'b0, 32'h0000_000A, 32'd0, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd3, 1'b0, 32'h0000_000B, 32'd0, 5'd3, 5'd3);
`ifdef WB_REGFILE_BYPASS_EN
    check("same_pre_rd1", bus.read_data1, 32'h0000_000B);
    check("same_pre_rd2", bus.read_data2, 32'h0000_000B);
`else
    check("same_pre_rd1", bus.read_data1, 32'h0000_000A);
    check("same_pre_rd2", bus.read_data2, 32'h0000_000A);
`endif
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd3, 5'd3);
    check("same_post_rd1", bus.read_data1, 32'h0000_000B);
    check("same_post_rd2", bus.read_data2, 32'h0000_000B);

    // Bubble: all-zero MEM/WB for 10 cycles changes nothing.
    cnt_hold = {28'd0, bus.wb_count};
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0);
      tick();
      check("bubble_count", {28'd0, bus.wb_count}, cnt_hold);
    end
    drive(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd7, 5'd3);
    check("bubble_r7", bus.read_data1, 32'hDEAD_BEEF);
    check("bubble_r3", bus.read_data2, 32'h0000_000B);

    // Randomized writeback traffic against the model.
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom), 1'($urandom), $urandom, $urandom,
            5'($urandom), 5'($urandom));
      check_all("rand");
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 5'(i), 5'(31 - i));
      check_all("sweep");
    end

    // Mid-cycle reset clears immediately, without a clock edge.
    drive(1'b1, 5'd5, 1'b0, 32'h1234_5678, 32'd0, 5'd5, 5'd5);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd5, 5'd5);
    check("pre_rst_r5", bus.read_data1, 32'h1234_5678);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_r5", bus.read_data1, 32'd0);
    check("async_rst_count", {28'd0, bus.wb_count}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("async_rst_r5_after", bus.read_data2, 32'd0);

    // Wrap: 17 valid writes on a 4-bit counter ends at 1.
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 5'((i % 31) + 1), 1'b0, 32'(i * 3 + 1), 32'd0, 5'd0, 5'd0);
      tick();
    end
    drive(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd2, 5'd17);
    check("wrap_count", {28'd0, bus.wb_count}, 32'd1);
    check_all("wrap");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
